branch_seq: RTL
===============

Name: branch_seq

Overview:
- Control-step sequencer for conditional branch instructions (brzr/brnz/brpl/brmi).
- Acts as the consumer of the CON flip-flop. It strobes the condition evaluation, computes PC+C through Y/ALU/Z, then commits PCin only when CON is set.
- The main control unit hands over after instruction fetch (T0–T2) via a start pulse. The sequencer returns control with done.

Parameters:
- OPC_BR, 5'b10010, branch opcode compared against ir[31:27].
- STEP_W, 3, width of the step_dbg state encoding.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request from control unit; ir is valid in this cycle.
- ir  in  32  instruction register contents.
- con  in  1  output of the CON flip-flop.
- stall  in  1  freeze sequencer in its current step (memory/bus wait).
- busy  out  1  sequencer owns the datapath.
- done  out  1  one-cycle pulse on the final step.
- taken  out  1  registered; 1 if PCin was issued for the last branch.
- reject  out  1  one-cycle pulse: start seen with a non-branch opcode.
- gra  out  1  select Ra field for register read.
- rout  out  1  register file drives bus.
- con_in  out  1  load enable for the CON flip-flop.
- pc_out  out  1  PC drives bus.
- y_in  out  1  load Y.
- c_out  out  1  sign-extended C field drives bus.
- alu_add  out  1  ALU op = ADD.
- z_in  out  1  load Z.
- zlow_out  out  1  Zlow drives bus.
- pc_in  out  1  load PC from bus.
- step_dbg  out  STEP_W  current state encoding.

Behaviour:
- States: IDLE, T3, T4, T5, T6, DONE. Encoding: IDLE=0, T3=3, T4=4, T5=5, T6=6, DONE=7.
- Reset (clr=0, async):
  - State goes to IDLE.
  - All strobes, busy, done, reject and taken go to 0.
  - Reset asserted mid-sequence aborts immediately; pc_in is never issued afterwards.
- IDLE:
  - start=1 and ir[31:27]==OPC_BR → T3 next cycle.
  - start=1 and opcode mismatch → reject=1 for that one cycle only (registered: visible the cycle after start); stay IDLE.
  - start=0 → stay IDLE.
- Strobes are combinational from the current state and exclusive per step:
  - T3: gra, rout, con_in. CON captures the condition at the end of T3.
  - T4: pc_out, y_in.
  - T5: c_out, alu_add, z_in.
  - T6: zlow_out; pc_in = con. taken is registered from con at the T6→DONE edge.
  - DONE: done=1, all strobes 0; IDLE next cycle.
- busy=1 in T3..DONE inclusive; 0 in IDLE.
- Latency: start in cycle N → T3 in N+1, T6 in N+4, done in N+5, IDLE in N+6 (no stall).
- stall=1:
  - Holds the state; all strobes forced to 0 while stalled.
  - The step re-issues its strobes on the first cycle with stall=0.
  - stall has no effect in IDLE or DONE (DONE always proceeds).
- start while busy is ignored (no reject, no restart).
- start and stall both high in IDLE: start is accepted (stall is ignored in IDLE).
- con is sampled only in T6; changes on con in other steps have no effect.
- taken holds its value until the next T6 completes or reset.

Optional Feature:
- Macro BR_EARLY_EXIT_EN.
- When defined:
  - In T4, con=0 and stall=0 → transition directly to DONE, skipping T5/T6; taken set to 0.
  - T4 strobes are still issued that cycle.
  - Not-taken latency: done at N+3.
  - con=1 follows the normal path.
- When undefined: always the full T3–T6 path; con is ignored before T6.

Decomposition:
- Package branch_pkg holds:
  - state enum and encodings;
  - OPC_BR default;
  - condition-code constants for ir[20:19]: 00 zero, 01 nonzero, 10 positive, 11 negative (shared with the CON logic);
  - step-count constants.
- Sub-module branch_step_dec: purely combinational state→strobe decoder with stall masking.
- The top holds the FSM, taken/reject registers, and the early-exit logic.

Test Plan:
- Taken branch: ir=32'h9008_0010 (br, opc 10010), start at cycle 0, con=1 from cycle 2.
  - Strobes appear T3..T6 at cycles 1–4; pc_in=1 at cycle 4; done at cycle 5; taken=1; busy 1 for cycles 1–5.
- Not taken: same ir, con=0.
  - pc_in stays 0 throughout; done at cycle 5 (cycle 3 with BR_EARLY_EXIT_EN, with T5/T6 strobes never asserted); taken=0.
- Reject: start with ir[31:27]=5'b00011.
  - reject pulses once; busy stays 0; no strobes; state remains IDLE.
- Stall: stall=1 during cycles 2–3 of a taken branch.
  - State holds T4; strobes are 0 in cycles 2–3; pc_out/y_in reappear at cycle 4; done at cycle 7.
- Reset mid-op: clr=0 asynchronously during T5.
  - All outputs 0 immediately; pc_in never asserts; after release, a new start runs a full sequence.
- start while busy: second start at cycle 2.
  - Ignored: single done at cycle 5, no reject.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the conditional-branch step sequencer.
// Holds the state encoding, branch opcode, condition codes and step counts.
package branch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    localparam logic [4:0] OPC_BR_DEF = 5'b10010;

    // Condition field ir[20:19], decoded by the CON logic
    localparam logic [1:0] CC_ZERO     = 2'b00;
    localparam logic [1:0] CC_NONZERO  = 2'b01;
    localparam logic [1:0] CC_POSITIVE = 2'b10;
    localparam logic [1:0] CC_NEGATIVE = 2'b11;

    // Cycles from the start pulse to the done pulse, without stalls
    localparam int STEPS_FULL  = 5;
    localparam int STEPS_EARLY = 3;

    typedef struct packed {
        logic gra;
        logic rout;
        logic con_in;
        logic pc_out;
        logic y_in;
        logic c_out;
        logic alu_add;
        logic z_in;
        logic zlow_out;
        logic pc_in;
    } strobes_t;

endpackage

// File: rtl/branch_step_dec.sv
// Combinational step-to-strobe decoder; a stalled step drives no strobes.
module branch_step_dec
    import branch_pkg::*;
(
    input  state_t   state,
    input  logic     stall,
    input  logic     con,
    output strobes_t strobes
);

    always_comb begin
        strobes = '0;
        if (!stall) begin
            unique case (state)
                ST_T3: begin
                    strobes.gra    = 1'b1;
                    strobes.rout   = 1'b1;
                    strobes.con_in = 1'b1;
                end
                ST_T4: begin
                    strobes.pc_out = 1'b1;
                    strobes.y_in   = 1'b1;
                end
                ST_T5: begin
                    strobes.c_out   = 1'b1;
                    strobes.alu_add = 1'b1;
                    strobes.z_in    = 1'b1;
                end
                ST_T6: begin
                    strobes.zlow_out = 1'b1;
                    strobes.pc_in    = con;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/branch_seq.sv
// Branch sequencer: runs T3..T6 after fetch and commits PCin only when CON is set.
// Define BR_EARLY_EXIT_EN to finish a not-taken branch straight from T4.
module branch_seq
    import branch_pkg::*;
#(
    parameter logic [4:0] OPC_BR = OPC_BR_DEF,
    parameter int         STEP_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [31:0]       ir,
    input  logic              con,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              taken,
    output logic              reject,
    output logic              gra,
    output logic              rout,
    output logic              con_in,
    output logic              pc_out,
    output logic              y_in,
    output logic              c_out,
    output logic              alu_add,
    output logic              z_in,
    output logic              zlow_out,
    output logic              pc_in,
    output logic [STEP_W-1:0] step_dbg
);

    state_t   state_reg, state_next;
    logic     taken_reg, taken_next;
    logic     reject_reg, reject_next;
    logic     is_branch;
    strobes_t strobes;
    logic     unused_ir;

    assign is_branch = (ir[31:27] == OPC_BR);
    assign unused_ir = ^ir[26:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg  <= ST_IDLE;
            taken_reg  <= 1'b0;
            reject_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            taken_reg  <= taken_next;
            reject_reg <= reject_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        taken_next  = taken_reg;
        reject_next = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                // stall is deliberately ignored here so a start is never lost
                if (start) begin
                    if (is_branch) state_next  = ST_T3;
                    else           reject_next = 1'b1;
                end
            end
            ST_T3: if (!stall) state_next = ST_T4;
            ST_T4: begin
                if (!stall) begin
`ifdef BR_EARLY_EXIT_EN
                    if (!con) begin
                        state_next = ST_DONE;
                        taken_next = 1'b0;
                    end else begin
                        state_next = ST_T5;
                    end
`else
                    state_next = ST_T5;
`endif
                end
            end
            ST_T5: if (!stall) state_next = ST_T6;
            ST_T6: begin
                if (!stall) begin
                    state_next = ST_DONE;
                    taken_next = con;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    branch_step_dec u_dec (
        .state   (state_reg),
        .stall   (stall),
        .con     (con),
        .strobes (strobes)
    );

    assign gra      = strobes.gra;
    assign rout     = strobes.rout;
    assign con_in   = strobes.con_in;
    assign pc_out   = strobes.pc_out;
    assign y_in     = strobes.y_in;
    assign c_out    = strobes.c_out;
    assign alu_add  = strobes.alu_add;
    assign z_in     = strobes.z_in;
    assign zlow_out = strobes.zlow_out;
    assign pc_in    = strobes.pc_in;

    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign taken    = taken_reg;
    assign reject   = reject_reg;
    assign step_dbg = STEP_W'(state_reg);

endmodule
